// File: rtl/lose_screen_ctrl.sv
// Game-over overlay sequencer: freezes play, fades the background, blinks the lose text,
// then holds until a debounced restart press. One-cycle registered pixel path.
module lose_screen_ctrl #(
  parameter logic [23:0] TEXT_RGB         = 24'hFF0000,
  parameter int          FADE_STEP_FRAMES = 8,
  parameter int          BLINK_FRAMES     = 15,
  parameter int          BLINK_TOGGLES    = 6,
  parameter int          DEBOUNCE_CYCLES  = 500000,
  parameter int          CNT_W            = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic [31:0] row,
  input  logic [31:0] col,
  input  logic        islose,
  input  logic [23:0] game_rgb,
  input  logic        lose_evt,
  input  logic        restart_btn,
  output logic [23:0] rgb_out,
  output logic        rgb_valid,
  output logic        game_freeze,
  output logic        restart_req
);

  typedef enum logic [1:0] {S_PLAY, S_FADE, S_BLINK, S_HOLD} state_t;

  localparam int FC_W = 8;
  localparam int TG_W = 8;
  localparam logic [FC_W-1:0]  FADE_LAST  = FC_W'(FADE_STEP_FRAMES - 1);
  localparam logic [FC_W-1:0]  BLINK_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [TG_W-1:0]  TOG_LAST   = TG_W'(BLINK_TOGGLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t            r_state;
  logic [FC_W-1:0]   r_frame_cnt;
  logic [1:0]        r_fade_lvl;
  logic              r_text_on;
  logic [TG_W-1:0]   r_toggles;
  logic              r_game_freeze;
  logic              r_restart_req;

  logic              r_sync1, r_sync2;
  logic              r_db_lvl, r_db_lvl_d;
  logic [CNT_W-1:0]  r_db_cnt;
  logic              w_db_rise;

  state_t            r_disp_state;
  logic [1:0]        r_disp_fade;
  logic              r_disp_text_on;
  logic [23:0]       r_rgb_out;
  logic              r_rgb_valid;
  logic [23:0]       w_pix;

  // Position only matters to the upstream hit tester.
  logic              w_unused_pos;
  assign w_unused_pos = ^{row, col};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_lvl   <= 1'b0;
      r_db_lvl_d <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1    <= restart_btn;
      r_sync2    <= r_sync1;
      r_db_lvl_d <= r_db_lvl;
      if (r_sync2 != r_db_lvl) begin
        if (r_db_cnt == DB_LAST) begin
          r_db_lvl <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Only a fresh press seen while holding restarts; a button held into HOLD never edges.
  assign w_db_rise = r_db_lvl & ~r_db_lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_PLAY;
      r_frame_cnt   <= '0;
      r_fade_lvl    <= 2'd0;
      r_text_on     <= 1'b0;
      r_toggles     <= '0;
      r_game_freeze <= 1'b0;
      r_restart_req <= 1'b0;
    end else begin
      r_restart_req <= 1'b0;
      case (r_state)
        S_PLAY: begin
          if (lose_evt) begin
            r_state       <= S_FADE;
            r_fade_lvl    <= 2'd1;
            r_frame_cnt   <= '0;
            r_game_freeze <= 1'b1;
          end
        end
        S_FADE: begin
          if (frame_start) begin
            if (r_frame_cnt == FADE_LAST) begin
              r_frame_cnt <= '0;
              if (r_fade_lvl == 2'd3) begin
                r_state   <= S_BLINK;
                r_text_on <= 1'b1;
                r_toggles <= '0;
              end else begin
                r_fade_lvl <= r_fade_lvl + 2'd1;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        S_BLINK: begin
          if (frame_start) begin
            if (r_frame_cnt == BLINK_LAST) begin
              r_frame_cnt <= '0;
              r_toggles   <= r_toggles + 1'b1;
              if (r_toggles == TOG_LAST) begin
                r_state   <= S_HOLD;
                r_text_on <= 1'b1;
              end else begin
                r_text_on <= ~r_text_on;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_db_rise) begin
            r_state       <= S_PLAY;
            r_restart_req <= 1'b1;
            r_game_freeze <= 1'b0;
            r_fade_lvl    <= 2'd0;
            r_text_on     <= 1'b0;
            r_frame_cnt   <= '0;
            r_toggles     <= '0;
          end
        end
        default: r_state <= S_PLAY;
      endcase
    end
  end

  function automatic logic [23:0] shr_rgb(input logic [23:0] c, input logic [1:0] f);
    return {c[23:16] >> f, c[15:8] >> f, c[7:0] >> f};
  endfunction

  always_comb begin
    w_pix = game_rgb;
    case (r_disp_state)
      S_PLAY:  w_pix = game_rgb;
      S_FADE:  w_pix = shr_rgb(game_rgb, r_disp_fade);
      S_BLINK: w_pix = (islose && r_disp_text_on) ? TEXT_RGB : shr_rgb(game_rgb, 2'd3);
      S_HOLD:  w_pix = islose ? TEXT_RGB : shr_rgb(game_rgb, 2'd3);
      default: w_pix = game_rgb;
    endcase
  end

  // Latches sample the pre-update state, so a pixel sharing a cycle with frame_start sees the old mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_state   <= S_PLAY;
      r_disp_fade    <= 2'd0;
      r_disp_text_on <= 1'b0;
      r_rgb_out      <= 24'd0;
      r_rgb_valid    <= 1'b0;
    end else begin
      if (frame_start) begin
        r_disp_state   <= r_state;
        r_disp_fade    <= r_fade_lvl;
        r_disp_text_on <= r_text_on;
      end
      r_rgb_valid <= pix_valid;
      if (pix_valid) r_rgb_out <= w_pix;
    end
  end

  assign rgb_out     = r_rgb_out;
  assign rgb_valid   = r_rgb_valid;
  assign game_freeze = r_game_freeze;
  assign restart_req = r_restart_req;

endmodule

// File: tb/tb_lose_screen_ctrl.sv
// Directed bench for lose_screen_ctrl: scoreboard queue for pixel results, assertions for control outputs.
module tb_lose_screen_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, pix_valid = 1'b0, frame_start = 1'b0;
  logic        islose = 1'b0, lose_evt = 1'b0, restart_btn = 1'b0;
  logic [31:0] row = 32'd0, col = 32'd0;
  logic [23:0] game_rgb = 24'd0;
  logic [23:0] rgb_out;
  logic        rgb_valid, game_freeze, restart_req;

  int          nvec = 0, nerr = 0, rr_cnt = 0;
  logic [23:0] exp_q[$];

  localparam logic [23:0] TXT = 24'hFF0000;
  localparam logic [23:0] G   = 24'h80FF40;
  localparam logic [23:0] F1  = 24'h407F20;
  localparam logic [23:0] F2  = 24'h203F10;
  localparam logic [23:0] F3  = 24'h101F08;

  lose_screen_ctrl #(
    .TEXT_RGB(24'hFF0000), .FADE_STEP_FRAMES(2), .BLINK_FRAMES(2),
    .BLINK_TOGGLES(4), .DEBOUNCE_CYCLES(4), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .frame_start(frame_start),
    .row(row), .col(col), .islose(islose), .game_rgb(game_rgb),
    .lose_evt(lose_evt), .restart_btn(restart_btn),
    .rgb_out(rgb_out), .rgb_valid(rgb_valid), .game_freeze(game_freeze),
    .restart_req(restart_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    logic [23:0] e;
    if (restart_req) rr_cnt++;
    if (rgb_valid && rst_n) begin
      nvec++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        assert (rgb_out === e) else begin
          nerr++;
          $error("FAIL pixel observed=%h expected=%h", rgb_out, e);
        end
      end else begin
        nerr++;
        $error("FAIL pixel_extra observed=%h expected=none", rgb_out);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic pix(input logic [23:0] c, input logic hit, input logic [23:0] e);
    @(negedge clk); pix_valid = 1'b1; game_rgb = c; islose = hit; exp_q.push_back(e);
    @(negedge clk); pix_valid = 1'b0;
  endtask

  task automatic pixf(input logic [23:0] c, input logic hit, input logic [23:0] e);
    @(negedge clk); pix_valid = 1'b1; frame_start = 1'b1; game_rgb = c; islose = hit;
    exp_q.push_back(e);
    @(negedge clk); pix_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic lose_pulse();
    @(negedge clk); lose_evt = 1'b1;
    @(negedge clk); lose_evt = 1'b0;
  endtask

  task automatic to_hold();
    lose_pulse();
    repeat (15) frame();
    pix(G, 1'b1, TXT);
  endtask

  initial begin
    logic seen;
    tick(2);
    chk("rst_rgb_out", rgb_out, 24'h0);
    chk("rst_rgb_valid", 24'(rgb_valid), 24'h0);
    chk("rst_freeze", 24'(game_freeze), 24'h0);
    chk("rst_restart", 24'(restart_req), 24'h0);
    @(negedge clk); rst_n = 1'b1;

    pix(G, 1'b1, G);
    chk("play_freeze", 24'(game_freeze), 24'h0);

    lose_pulse();
    chk("lose_freeze", 24'(game_freeze), 24'h1);
    pix(G, 1'b1, G);
    pixf(G, 1'b1, G);
    pix(G, 1'b1, F1);
    frame(); pix(G, 1'b0, F1);
    frame(); pix(G, 1'b1, F2);
    frame(); pix(G, 1'b1, F2);
    frame(); pix(G, 1'b1, F3);
    frame(); pix(G, 1'b1, F3);

    for (int f = 7; f <= 14; f++) begin
      if (f == 11) restart_btn = 1'b1;
      frame();
      pix(G, 1'b1, ((((f - 7) / 2) % 2) == 0) ? TXT : F3);
      if (f == 7) pix(G, 1'b0, F3);
    end
    frame();
    pix(G, 1'b1, TXT);
    pix(G, 1'b0, F3);
    pix(24'h123456, 1'b1, TXT);
    tick(10);
    chk("held_btn_no_restart", 24'(rr_cnt), 24'd0);
    chk("hold_freeze", 24'(game_freeze), 24'h1);

    restart_btn = 1'b0;
    tick(10);
    chk("release_no_restart", 24'(rr_cnt), 24'd0);
    restart_btn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (restart_req) begin seen = 1'b1; break; end
    end
    chk("restart_seen", 24'(seen), 24'h1);
    chk("restart_unfreeze", 24'(game_freeze), 24'h0);
    tick(5);
    chk("restart_one_pulse", 24'(rr_cnt), 24'd1);
    restart_btn = 1'b0;
    frame();
    pix(G, 1'b1, G);

    to_hold();
    @(negedge clk); restart_btn = 1'b1;
    @(negedge clk); restart_btn = 1'b0;
    @(negedge clk); restart_btn = 1'b1;
    @(negedge clk); restart_btn = 1'b0;
    tick(10);
    chk("bounce_no_restart", 24'(rr_cnt), 24'd1);
    chk("bounce_freeze", 24'(game_freeze), 24'h1);

    // Synchronizer (2) plus debounce (4) puts the edge on the 7th rising edge after the press.
    @(negedge clk); restart_btn = 1'b1;
    tick(5);
    @(negedge clk); lose_evt = 1'b1;
    @(negedge clk); lose_evt = 1'b0;
    chk("race_restart", 24'(restart_req), 24'h1);
    chk("race_unfreeze", 24'(game_freeze), 24'h0);
    tick(3);
    chk("race_no_refade", 24'(game_freeze), 24'h0);
    chk("race_pulses", 24'(rr_cnt), 24'd2);
    frame();
    pix(G, 1'b1, G);
    restart_btn = 1'b0;
    tick(10);

    lose_pulse();
    frame(); frame();
    @(negedge clk); pix_valid = 1'b1; game_rgb = G; islose = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 24'(rgb_valid), 24'h1);
    chk("pre_rst_rgb", rgb_out, F1);
    pix_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rgb_out", rgb_out, 24'h0);
    chk("async_rgb_valid", 24'(rgb_valid), 24'h0);
    chk("async_freeze", 24'(game_freeze), 24'h0);
    chk("async_restart", 24'(restart_req), 24'h0);
    @(negedge clk); rst_n = 1'b1;
    chk("rst_no_restart", 24'(rr_cnt), 24'd2);
    pix(G, 1'b1, G);
    lose_pulse();
    chk("relose_freeze", 24'(game_freeze), 24'h1);
    frame();
    pix(G, 1'b1, F1);

    tick(3);
    chk("queue_drain", 24'(exp_q.size()), 24'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/lose_screen_ctrl.md
Name: lose_screen_ctrl

Overview:
- Pixel-stage sequencer that sits directly downstream of the lose-text hit tester.
- It consumes the per-pixel islose flag together with the game's own pixel colour, and runs a game-over sequence: freeze the game, fade the background, blink the "GAME OVER!" text, then hold until restart.
- Outputs the composited RGB to the VGA output stage and issues a one-cycle restart request back to game logic.

Parameters:
TEXT_RGB, 24'hFF0000, colour of lose-text pixels
FADE_STEP_FRAMES, 8, frames per fade level step
BLINK_FRAMES, 15, frames per text on/off half-period
BLINK_TOGGLES, 6, number of text toggles before HOLD
DEBOUNCE_CYCLES, 500000, cycles restart button must be stable to register
CNT_W, 20, width of the debounce counter (must hold DEBOUNCE_CYCLES)

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
pix_valid  input  1  row/col/game_rgb/islose valid this cycle
frame_start  input  1  one-cycle pulse per frame, issued in vertical blanking
row  input  32  current pixel row (informational, passed to the hit tester)
col  input  32  current pixel column
islose  input  1  hit-test result for row/col, same cycle as pix_valid
game_rgb  input  24  game pixel colour {R[7:0],G[7:0],B[7:0]}
lose_evt  input  1  one-cycle pulse from game logic: player lost
restart_btn  input  1  raw asynchronous pushbutton, active-high
rgb_out  output  24  composited pixel colour
rgb_valid  output  1  rgb_out valid
game_freeze  output  1  high while the game must not advance
restart_req  output  1  one-cycle restart pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=PLAY; rgb_out=0, rgb_valid=0, game_freeze=0, restart_req=0. All internal counters are 0, fade_lvl=0, text_on=0, and the display latches are cleared.
- States:
  - PLAY: no overlay.
  - FADE: background darkens in steps; no text.
  - BLINK: text toggles on/off.
  - HOLD: text steady; waits for restart.
- PLAY->FADE:
  - Triggered by lose_evt.
  - fade_lvl set to 1 and frame counter cleared.
  - game_freeze goes high on the next cycle.
- FADE:
  - Each frame_start increments frame_cnt.
  - When frame_cnt reaches FADE_STEP_FRAMES: frame_cnt=0 and fade_lvl increments.
  - When the step would take fade_lvl past 3: go to BLINK with text_on=1, toggles=0, fade_lvl held at 3.
- BLINK:
  - Every BLINK_FRAMES frame_starts, invert text_on and increment toggles.
  - When toggles reaches BLINK_TOGGLES: go to HOLD with text_on forced to 1.
- HOLD->PLAY:
  - Triggered by a debounced rising edge of restart_btn.
  - restart_req=1 for exactly one cycle, same cycle as the state change.
  - game_freeze=0, fade_lvl=0, text_on=0.
- Ignored and priority events:
  - lose_evt outside PLAY is ignored.
  - In HOLD, a restart edge and lose_evt in the same cycle: restart wins and lose_evt is dropped.
  - Button edges in PLAY, FADE or BLINK are ignored. A button already held when HOLD is entered does not restart; it must be released and pressed again.
- Debounce:
  - restart_btn passes a 2-flop synchronizer.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the counter.
  - Edge detect runs on the debounced level.
- Display latch:
  - disp_state, disp_fade and disp_text_on are copied from the live state only on frame_start, so the mode never changes mid-frame.
  - If pix_valid and frame_start coincide, that pixel uses the pre-update latches.
- Pixel path, 1-cycle latency:
  - rgb_valid(t+1) = pix_valid(t).
  - rgb_out updates only when pix_valid; otherwise it holds and rgb_valid=0.
- Compositing, where f = disp_fade:
  - PLAY: game_rgb.
  - FADE: each 8-bit channel >> f; islose is ignored.
  - BLINK: TEXT_RGB if islose and disp_text_on; otherwise each channel >> 3.
  - HOLD: TEXT_RGB if islose; otherwise each channel >> 3.
  - Shifts are logical per channel with no carry between channels.
- Reset mid-sequence: immediately returns to PLAY outputs. No restart_req is generated.

Test Plan:
- Parameters for all scenarios: FADE_STEP_FRAMES=2, BLINK_FRAMES=2, BLINK_TOGGLES=4, DEBOUNCE_CYCLES=4.
- Reset then PLAY, game_rgb=24'h80FF40, islose=1 -> rgb_out=24'h80FF40 one cycle after pix_valid; game_freeze=0.
- lose_evt pulse -> game_freeze=1 next cycle. Pixel colour must not change until the next frame_start; in that frame game_rgb=24'h80FF40 gives 24'h407F20. Levels 2 and 3 follow after 2 frames each (24'h203F10, 24'h101F08). BLINK is entered after 6 frames.
- In BLINK with islose=1 -> TEXT_RGB and 24'h101F08 alternate every 2 frames. HOLD is entered after 4 toggles (8 frames); rgb_out is then constant 24'hFF0000 on text pixels.
- Button held from BLINK into HOLD -> no restart_req. Release, then press stable 4+ cycles -> exactly one restart_req pulse; state PLAY; game_freeze=0.
- In HOLD, button bounces 1-0-1 within 3 cycles -> no restart_req. Next, lose_evt and a debounced edge in the same cycle -> restart_req=1, state PLAY, no re-entry to FADE.
- rst_n low mid-FADE -> all outputs 0 asynchronously. After release, lose_evt restarts the sequence from fade_lvl=1.
